l1_init_mem: RTL and testbench
==============================

L1_INIT_MEM -- requirements
Module: l1_init_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width per way in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 1024, words per way; must be a power of 2 and >= 2.
REQ-003 SHALL have parameter WAYS, default 2, number of parallel ways sharing one address.
REQ-004 SHALL have parameter INIT_VAL, default all-zeros, WIDTH-bit value written to every word during init.
REQ-005 SHALL have port CLK  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port EN  input  1  access request, sampled when READY=1.
REQ-008 SHALL have port ADDR  input  $clog2(DEPTH)  word index, common to all ways.
REQ-009 SHALL have port WAY_WE  input  WAYS  per-way write enable; any bit set makes the access a write.
REQ-010 SHALL have port BE  input  WIDTH/8  byte enables, applied to every written way.
REQ-011 SHALL have port WDATA  input  WIDTH  write data, applied to every written way.
REQ-012 SHALL have port FLUSH  input  1  single-cycle request to re-initialise the whole array.
REQ-013 SHALL have port RDATA  output  WAYS*WIDTH  read data; way w at bits [w*WIDTH +: WIDTH].
REQ-014 SHALL have port RVALID  output  1  RDATA updated by a read this cycle.
REQ-015 SHALL have port READY  output  1  array initialised and accepting accesses.

Function
REQ-016 SHALL implement FSM states INIT and RUN; READY = (state == RUN), driven from a register.
REQ-017 In INIT, each cycle SHALL write INIT_VAL to all bytes of all ways at init counter CNT, then increment CNT.
REQ-018 In INIT with CNT == DEPTH-1, SHALL transition to RUN on that edge; CNT is held at 0 in RUN.
REQ-019 Init sweep SHALL take exactly DEPTH cycles from reset deassertion or from the FLUSH edge to READY=1.
REQ-020 In RUN, FLUSH=1 SHALL move the FSM to INIT with CNT=0 on the next edge.
REQ-021 FLUSH while in INIT SHALL be ignored; the sweep neither restarts nor extends.
REQ-022 In RUN, an access with FLUSH=1 in the same cycle SHALL still be performed; the flush starts on the following cycle.
REQ-023 In RUN, EN=1 with WAY_WE != 0 SHALL write WDATA to byte lanes with BE[b]=1 of each way with WAY_WE[w]=1; other bytes and ways are unchanged.
REQ-024 A write with BE == 0 SHALL leave the array unchanged and otherwise complete normally.
REQ-025 In RUN, EN=1 with WAY_WE == 0 SHALL read all ways at ADDR; RDATA and RVALID=1 are registered, one cycle of latency.
REQ-026 RVALID SHALL be 1 for exactly one cycle per accepted read and 0 after writes, idle cycles and all INIT cycles.
REQ-027 RDATA SHALL hold its last read value until the next accepted read, including across INIT.
REQ-028 Accesses presented while READY=0 SHALL be dropped with no array write and no RVALID; the requester must retry.
REQ-029 A read to an address written in the immediately preceding cycle SHALL return the new data.
REQ-030 Storage SHALL be one single-port array per way with a byte-lane write mask; no dual-port behaviour is required.

Reset
REQ-031 When RST_N=0, the block SHALL asynchronously set state=INIT, CNT=0, READY=0, RVALID=0, RDATA=0.
REQ-032 Reset asserted mid-sweep or mid-operation SHALL abort it; after release a full DEPTH-cycle sweep SHALL run.
REQ-033 Array contents are not reset directly; they are defined only by the init sweep.

Verification (WIDTH=32, DEPTH=16, WAYS=2, INIT_VAL=32'hA5A5A5A5)
REQ-034 Release reset, hold EN=0 -> READY=0 for exactly 16 cycles, then READY=1; a read of ADDR=7 returns RDATA=64'hA5A5A5A5_A5A5A5A5 with RVALID=1 one cycle later.
REQ-035 Write ADDR=3, WAY_WE=2'b10, BE=4'b0101, WDATA=32'h11223344, then read ADDR=3 on the next cycle -> RDATA=64'hA522A544_A5A5A5A5.
REQ-036 Write ADDR=5 with WAY_WE=2'b11 and FLUSH=1 in the same cycle -> READY=0 on the next cycle for 16 cycles; a read of ADDR=5 afterwards returns INIT_VAL in both ways.
REQ-037 Issue a write and a read while READY=0 -> RVALID stays 0 and contents still equal INIT_VAL after READY=1.
REQ-038 Assert RST_N=0 at sweep cycle 8, release after 2 cycles -> READY rises exactly 16 cycles after release; RDATA=0 and RVALID=0 during reset.

Source files
------------

// File: rtl/l1_init_mem.sv
// l1_init_mem: multi-way single-port word array with a self-initialising sweep.
// After reset or FLUSH, every word of every way is written with INIT_VAL, one
// address per cycle. READY rises once the sweep has covered the whole array.
// Reads have one cycle of latency. RDATA holds its value until the next read.
module l1_init_mem #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       WAYS     = 2,
  parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic [$clog2(DEPTH)-1:0]   ADDR,
  input  logic [WAYS-1:0]            WAY_WE,
  input  logic [WIDTH/8-1:0]         BE,
  input  logic [WIDTH-1:0]           WDATA,
  input  logic                       FLUSH,
  output logic [WAYS*WIDTH-1:0]      RDATA,
  output logic                       RVALID,
  output logic                       READY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = WIDTH / 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;

  logic [WIDTH-1:0] mem [WAYS][DEPTH];

  logic [WAYS-1:0]  mem_we_c;
  logic [AW-1:0]    mem_addr_c;
  logic [BW-1:0]    mem_be_c;
  logic [WIDTH-1:0] mem_wdata_c;
  logic             rd_c;

  // Sweep/run sequencer; READY is registered alongside the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_INIT;
      cnt   <= '0;
      READY <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == AW'(DEPTH - 1)) begin
            state <= ST_RUN;
            cnt   <= '0;
            READY <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        ST_RUN: begin
          if (FLUSH) begin
            state <= ST_INIT;
            cnt   <= '0;
            READY <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          READY <= 1'b0;
        end
      endcase
    end
  end

  // Array write port: the sweep owns it in INIT, the requester in RUN.
  always_comb begin
    mem_we_c    = '0;
    mem_addr_c  = ADDR;
    mem_be_c    = BE;
    mem_wdata_c = WDATA;
    if (state == ST_INIT) begin
      mem_we_c    = '1;
      mem_addr_c  = cnt;
      mem_be_c    = '1;
      mem_wdata_c = INIT_VAL;
    end else if (EN) begin
      mem_we_c = WAY_WE;
    end
  end

  // Read is accepted only in RUN with no way write-enabled.
  always_comb begin
    rd_c = (state == ST_RUN) && EN && (WAY_WE == '0);
  end

  // Per-way storage with byte-lane write mask; contents have no reset.
  always_ff @(posedge CLK) begin
    for (int w = 0; w < int'(WAYS); w++) begin
      for (int b = 0; b < int'(BW); b++) begin
        if (mem_we_c[w] && mem_be_c[b]) begin
          mem[w][mem_addr_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
        end
      end
    end
  end

  // Registered read data; RDATA only updates on an accepted read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
    end else begin
      RVALID <= rd_c;
      if (rd_c) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          RDATA[w*WIDTH +: WIDTH] <= mem[w][ADDR];
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_init_mem.sv
// Randomised self-checking bench for l1_init_mem against a word-level model.
module tb_l1_init_mem;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WAYS  = 2;
  localparam logic [31:0] IV    = 32'hA5A5A5A5;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic [3:0]  ADDR;
  logic [1:0]  WAY_WE;
  logic [3:0]  BE;
  logic [31:0] WDATA;
  logic        FLUSH;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        READY;

  l1_init_mem #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .WAYS(WAYS), .INIT_VAL(IV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .ADDR(ADDR), .WAY_WE(WAY_WE),
    .BE(BE), .WDATA(WDATA), .FLUSH(FLUSH), .RDATA(RDATA),
    .RVALID(RVALID), .READY(READY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents, remaining sweep cycles, expected outputs.
  logic [31:0] model [2][16];
  int          busy;
  logic        exp_rvalid;
  logic [63:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill();
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 16; a++)
        model[w][a] = IV;
  endtask

  // One clock edge: apply inputs, advance model, compare outputs after the edge.
  task automatic cycle(input logic en, input logic [3:0] addr, input logic [1:0] we,
                       input logic [3:0] be, input logic [31:0] wd, input logic fl);
    EN = en; ADDR = addr; WAY_WE = we; BE = be; WDATA = wd; FLUSH = fl;
    @(posedge CLK);
    if (busy > 0) begin
      busy--;
      exp_rvalid = 1'b0;
      if (busy == 0) model_fill();
    end else begin
      exp_rvalid = 1'b0;
      if (en) begin
        if (we != 2'b00) begin
          for (int w = 0; w < 2; w++)
            if (we[w])
              for (int b = 0; b < 4; b++)
                if (be[b]) model[w][addr][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          exp_rvalid = 1'b1;
          exp_rdata  = {model[1][addr], model[0][addr]};
        end
      end
      if (fl) busy = DEPTH;
    end
    #1;
    chk("ready",  64'(READY),  64'(busy == 0));
    chk("rvalid", 64'(RVALID), 64'(exp_rvalid));
    chk("rdata",  RDATA, exp_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 2'b00, 4'd0, 32'd0, 1'b0);
  endtask

  // Assert reset asynchronously for n edges, then release.
  task automatic do_reset(input int n);
    RST_N = 1'b0;
    #1;
    busy = DEPTH; exp_rvalid = 1'b0; exp_rdata = '0;
    chk("rst_rdata",  RDATA, 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_ready",  64'(READY), 64'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      chk("rst_rdata_hold",  RDATA, 64'd0);
      chk("rst_rvalid_hold", 64'(RVALID), 64'd0);
    end
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; ADDR = '0; WAY_WE = '0; BE = '0; WDATA = '0; FLUSH = 1'b0;
    busy = DEPTH; exp_rvalid = 1'b0; exp_rdata = '0;
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 16; a++)
        model[w][a] = 32'hx;
    @(posedge CLK); #1;
    do_reset(2);

    // Initial sweep, then read address 7.
    idle(DEPTH);
    cycle(1'b1, 4'd7, 2'b00, 4'd0, 32'd0, 1'b0);
    chk("sweep_read7", RDATA, 64'hA5A5A5A5_A5A5A5A5);

    // Partial byte write to way 1, read back the next cycle.
    cycle(1'b1, 4'd3, 2'b10, 4'b0101, 32'h11223344, 1'b0);
    cycle(1'b1, 4'd3, 2'b00, 4'd0, 32'd0, 1'b0);
    chk("bytewrite_read3", RDATA, 64'hA522A544_A5A5A5A5);

    // BE==0 write is a no-op.
    cycle(1'b1, 4'd3, 2'b11, 4'b0000, 32'hDEADBEEF, 1'b0);
    cycle(1'b1, 4'd3, 2'b00, 4'd0, 32'd0, 1'b0);

    // Write with concurrent FLUSH; accesses during the sweep are dropped.
    cycle(1'b1, 4'd5, 2'b11, 4'b1111, 32'h12345678, 1'b1);
    cycle(1'b1, 4'd6, 2'b01, 4'b1111, 32'hCAFEF00D, 1'b0);
    cycle(1'b1, 4'd6, 2'b00, 4'd0, 32'd0, 1'b1);
    idle(DEPTH - 2);
    cycle(1'b1, 4'd5, 2'b00, 4'd0, 32'd0, 1'b0);
    chk("flush_read5", RDATA, 64'hA5A5A5A5_A5A5A5A5);
    cycle(1'b1, 4'd6, 2'b00, 4'd0, 32'd0, 1'b0);
    chk("dropped_read6", RDATA, 64'hA5A5A5A5_A5A5A5A5);

    // Reset at sweep cycle 8, released after 2 cycles.
    cycle(1'b1, 4'd9, 2'b01, 4'b1111, 32'h0BADF00D, 1'b1);
    idle(8);
    do_reset(2);
    idle(DEPTH);
    cycle(1'b1, 4'd9, 2'b00, 4'd0, 32'd0, 1'b0);
    chk("rst_mid_sweep_read9", RDATA, 64'hA5A5A5A5_A5A5A5A5);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic        en, fl;
      logic [1:0]  we;
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0) ? 2'(($urandom_range(1, 3))) : 2'b00;
      fl = ($urandom_range(0, 49) == 0);
      cycle(en, 4'($urandom_range(0, 15)), we, 4'($urandom_range(0, 15)), $urandom, fl);
    end

    // Final readback of every address once the array is ready.
    idle(DEPTH + 1);
    for (int a = 0; a < 16; a++)
      cycle(1'b1, 4'(a), 2'b00, 4'd0, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
